// File: rtl/m_multicycle_controller.sv
// m_multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer with memory-ready handshake, illegal-opcode trap and retire counter
module m_multicycle_controller #(
    parameter int OPT_W = 3,
    parameter int ALU_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [OPT_W-1:0] i_opt,
    input  logic             i_zero,
    input  logic             i_memRdy,
    output logic             o_pcWr,
    output logic             o_irWr,
    output logic [ALU_W-1:0] o_aluCtl,
    output logic             o_aluSrc,
    output logic             o_memRd,
    output logic             o_memWr,
    output logic             o_memToReg,
    output logic             o_regWr,
    output logic             o_br,
    output logic             o_done,
    output logic             o_illegal,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_retired
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;
    state_t state, nxt;
    logic [OPT_W-1:0] op;
    logic is_ld, is_st, is_beq, alu_sub, alu_imm;
    assign is_ld   = op == OPT_W'(3);
    assign is_st   = op == OPT_W'(4);
    assign is_beq  = op == OPT_W'(5);
    assign alu_sub = op == OPT_W'(2) || is_beq;
    assign alu_imm = op == OPT_W'(1) || is_ld || is_st;
    assign o_state = state;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            op        <= '0;
            o_retired <= '0;
        end else begin
            state <= nxt;
            if (state == DECODE) op <= i_opt;
            if (o_done) o_retired <= o_retired + 1'b1;
        end
    end
    always_comb begin
        nxt        = state;
        o_pcWr     = 1'b0;
        o_irWr     = 1'b0;
        o_aluCtl   = '0;
        o_aluSrc   = 1'b0;
        o_memRd    = 1'b0;
        o_memWr    = 1'b0;
        o_memToReg = 1'b0;
        o_regWr    = 1'b0;
        o_br       = 1'b0;
        o_done     = 1'b0;
        o_illegal  = 1'b0;
        case (state)
            IDLE: nxt = FETCH;
            FETCH: begin
                o_memRd = 1'b1;
                o_irWr  = i_memRdy;
                o_pcWr  = i_memRdy;
                nxt     = i_memRdy ? DECODE : FETCH;
            end
            // legality is judged on the live opcode; the latch only becomes visible in EXEC
            DECODE: nxt = i_opt < OPT_W'(6) ? EXEC : TRAP;
            EXEC: begin
                o_aluCtl = ALU_W'(alu_sub);
                o_aluSrc = alu_imm;
                o_pcWr   = is_beq && i_zero;
                o_br     = is_beq && i_zero;
                o_done   = is_beq;
                nxt      = is_beq ? FETCH : (is_ld || is_st) ? MEM : WB;
            end
            MEM: begin
                o_aluCtl = ALU_W'(alu_sub);
                o_aluSrc = alu_imm;
                o_memRd  = is_ld;
                o_memWr  = is_st;
                o_done   = is_st && i_memRdy;
                nxt      = !i_memRdy ? MEM : is_ld ? WB : FETCH;
            end
            WB: begin
                o_regWr    = 1'b1;
                o_memToReg = is_ld;
                o_done     = 1'b1;
                nxt        = FETCH;
            end
            TRAP: o_illegal = 1'b1;
            default: nxt = IDLE;
        endcase
    end
endmodule
